// File: rtl/narrowing_saturator.sv
// narrowing_saturator
// Two-stage return path of the double-width adder: rounds a 2W-bit value with
// 2F fractional bits down to F fractional bits (S1), then clamps it to the
// W-bit signed range (S2). Valid/ready on both sides; clamps are flagged per
// sample and counted in a sticky 8-bit counter.
// Build option: define ROUND_NEAREST_EN for round-half-up; otherwise the
// narrowing truncates (floor toward -inf).
// W defaults to 16, matching the project-wide single-word width N.

module narrowing_saturator #(
    parameter int W = 16,
    parameter int F = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2*W-1:0]   in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sat,
    output logic [7:0]       sat_count,
    input  logic             sat_clear
);

    // width of the rounded value: sign-extended input minus the dropped bits
    localparam int SW = 2*W + 1 - F;

`ifdef ROUND_NEAREST_EN
    localparam logic [2*W:0] RND = (2*W+1)'(1) << (F-1);
`else
    localparam logic [2*W:0] RND = '0;
`endif

    localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

    logic            advance;
    logic [2*W:0]    s1_sum;
    logic [SW-1:0]   s1_data;
    logic            s1_valid;
    logic [SW-W:0]   s1_high;
    logic            s1_fits;
    logic [W-1:0]    sat_data;
    logic            sat_flag;
    logic            unused_round_bits;

    // whole pipeline moves together whenever the output register is free
    assign advance  = !out_valid || out_ready;
    // during reset the stages are being flushed, so input is "taken" and dropped
    assign in_ready = advance || reset;

    // S1 datapath: sign-extend, add rounding constant, drop F bits
    always_comb begin
        s1_sum = {in_data[2*W-1], in_data} + RND;
    end

    // fractional bits below the new LSB only matter through the carry
    assign unused_round_bits = ^s1_sum[F-1:0];

    // S2 datapath: value fits iff all bits above the W-bit sign agree with it
    always_comb begin
        s1_high  = s1_data[SW-1:W-1];
        s1_fits  = (s1_high == '0) || (s1_high == '1);
        sat_data = s1_data[W-1:0];
        sat_flag = 1'b0;
        if (!s1_fits) begin
            sat_flag = 1'b1;
            sat_data = s1_data[SW-1] ? SAT_NEG : SAT_POS;
        end
    end

    // S1 register: capture the rounded value or become empty
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else if (advance) begin
            s1_data  <= s1_sum[2*W:F];
            s1_valid <= in_valid;
        end
    end

    // S2 register: saturated result drives the outputs, held while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
        end else if (advance) begin
            out_data  <= sat_data;
            out_valid <= s1_valid;
            out_sat   <= s1_valid && sat_flag;
        end
    end

    // sticky clamp counter; clear beats a simultaneous increment
    always_ff @(posedge clk) begin
        if (reset || sat_clear) begin
            sat_count <= '0;
        end else if (advance && s1_valid && sat_flag && (sat_count != 8'hFF)) begin
            sat_count <= sat_count + 8'd1;
        end
    end

endmodule
